// File: rtl/decoder8_hold.sv
// rtl/decoder8_hold.sv - sequential 3-to-8 one-hot decoder with programmable hold and gap
module decoder8_hold #(
    parameter int HOLD       = 4,
    parameter int GAP        = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       code_valid,
    input  logic [2:0] code,
    output logic       code_ready,
    output logic [7:0] onehot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
    localparam logic [7:0] GAP_M1  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_code, w_code_nxt;
    logic       r_done, w_done_nxt;
    logic       r_started;
    logic       w_accept;
    logic [7:0] w_line;

    // r_started keeps ready low for the first cycle after reset release
    assign code_ready = r_started & (r_state == S_IDLE) & en & ~clr;
    assign w_accept   = code_ready & code_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_code    <= 3'd0;
            r_done    <= 1'b0;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_code    <= w_code_nxt;
            r_done    <= w_done_nxt;
            r_started <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_done_nxt  = 1'b0;
        if (clr) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = HOLD_M1;
                        w_code_nxt  = code;
                    end
                end
                S_HOLD: begin
                    if (en) begin
                        if (r_cnt == 8'd0) begin
                            w_done_nxt = 1'b1;
                            if (GAP > 0) begin
                                w_state_nxt = S_GAP;
                                w_cnt_nxt   = GAP_M1;
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_cnt_nxt   = 8'd0;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt - 8'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (en) begin
                        if (r_cnt == 8'd0) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    assign w_line = (r_state == S_HOLD) ? (8'd1 << r_code) : 8'd0;
    assign onehot = (ACTIVE_LOW != 0) ? ~w_line : w_line;
    assign busy   = (r_state == S_HOLD) || (r_state == S_GAP);
    assign done   = r_done;

endmodule

// File: tb/tb_decoder8_hold.sv
// tb/tb_decoder8_hold.sv - scoreboard bench for decoder8_hold (default and active-low/no-gap variants)
module tb_decoder8_hold;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b1;
    logic       code_valid = 1'b0;
    logic [2:0] code = 3'd0;

    logic       rdy0, busy0, done0;
    logic [7:0] oh0;
    logic       rdy1, busy1, done1;
    logic [7:0] oh1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         sel;
        logic [7:0] oh;
        logic       rdy;
        logic       busy;
        logic       done;
        string      name;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    decoder8_hold #(.HOLD(4), .GAP(1), .ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en),
        .code_valid(code_valid), .code(code),
        .code_ready(rdy0), .onehot(oh0), .busy(busy0), .done(done0)
    );

    decoder8_hold #(.HOLD(1), .GAP(0), .ACTIVE_LOW(1)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en),
        .code_valid(code_valid), .code(code),
        .code_ready(rdy1), .onehot(oh1), .busy(busy1), .done(done1)
    );

    // one row per cycle: inputs for the cycle and the outputs expected during it
    task automatic step(input bit sel, input logic r, input logic c_clr, input logic c_en,
                        input logic v, input logic [2:0] c, input logic [7:0] e_oh,
                        input logic e_rdy, input logic e_busy, input logic e_done,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = r;
        clr        = c_clr;
        en         = c_en;
        code_valid = v;
        code       = c;
        e.sel  = sel;
        e.oh   = e_oh;
        e.rdy  = e_rdy;
        e.busy = e_busy;
        e.done = e_done;
        e.name = nm;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [10:0] act, req;
            e = q.pop_front();
            act = e.sel ? {oh1, rdy1, busy1, done1} : {oh0, rdy0, busy0, done0};
            req = {e.oh, e.rdy, e.busy, e.done};
            checks++;
            if (act !== req) begin
                failures++;
                $display("FAIL %s: got onehot=%h ready=%b busy=%b done=%b, expected onehot=%h ready=%b busy=%b done=%b",
                         e.name, act[10:3], act[2], act[1], act[0], e.oh, e.rdy, e.busy, e.done);
            end
        end
        checks++;
        if ($countones(oh0) > 1) begin
            failures++;
            $display("FAIL overlap: got onehot=%h, expected at most one bit set", oh0);
        end
    end

    initial begin
        int bound;
        // reset then idle
        step(0, 0, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, "rst");
        step(0, 0, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, "rst");
        step(1, 0, 0, 1, 0, 3'd0, 8'hFF, 0, 0, 0, "rst_al");
        step(0, 1, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, "first_ready");
        step(0, 1, 0, 1, 0, 3'd0, 8'h00, 1, 0, 0, "idle_ready");

        // single decode of code 5
        step(0, 1, 0, 1, 1, 3'd5, 8'h00, 1, 0, 0, "single_acc");
        for (int k = 0; k < 4; k++)
            step(0, 1, 0, 1, 0, 3'd0, 8'h20, 0, 1, 0, "single_hold");
        step(0, 1, 0, 1, 0, 3'd0, 8'h00, 0, 1, 1, "single_gap");

        // back-to-back sweep with valid held high
        for (int c = 0; c < 8; c++) begin
            logic [7:0] exp_oh;
            logic [2:0] nxt;
            exp_oh = 8'd1 << c;
            nxt = 3'(c + 1);
            step(0, 1, 0, 1, 1, 3'(c), 8'h00, 1, 0, 0, "sweep_idle");
            for (int k = 0; k < 4; k++)
                step(0, 1, 0, 1, 1, nxt, exp_oh, 0, 1, 0, "sweep_hold");
            step(0, 1, 0, 1, 1, nxt, 8'h00, 0, 1, 1, "sweep_gap");
        end

        // enable freeze mid-hold
        step(0, 1, 0, 1, 1, 3'd3, 8'h00, 1, 0, 0, "frz_acc");
        step(0, 1, 0, 1, 0, 3'd0, 8'h08, 0, 1, 0, "frz_h1");
        step(0, 1, 0, 1, 0, 3'd0, 8'h08, 0, 1, 0, "frz_h2");
        for (int k = 0; k < 3; k++)
            step(0, 1, 0, 0, 0, 3'd0, 8'h08, 0, 1, 0, "frz_off");
        step(0, 1, 0, 1, 0, 3'd0, 8'h08, 0, 1, 0, "frz_h3");
        step(0, 1, 0, 1, 0, 3'd0, 8'h08, 0, 1, 0, "frz_h4");
        step(0, 1, 0, 1, 0, 3'd0, 8'h00, 0, 1, 1, "frz_gap");
        step(0, 1, 0, 0, 1, 3'd2, 8'h00, 0, 0, 0, "idle_en_off");
        step(0, 1, 0, 0, 1, 3'd2, 8'h00, 0, 0, 0, "idle_en_off");
        step(0, 1, 0, 1, 0, 3'd0, 8'h00, 1, 0, 0, "idle_en_on");

        // clear on the second hold cycle, then clear together with valid
        step(0, 1, 0, 1, 1, 3'd6, 8'h00, 1, 0, 0, "clr_acc");
        step(0, 1, 0, 1, 0, 3'd0, 8'h40, 0, 1, 0, "clr_h1");
        step(0, 1, 1, 1, 0, 3'd0, 8'h40, 0, 1, 0, "clr_h2");
        step(0, 1, 0, 1, 0, 3'd0, 8'h00, 1, 0, 0, "clr_after");
        step(0, 1, 1, 1, 1, 3'd1, 8'h00, 0, 0, 0, "clr_valid");
        step(0, 1, 0, 1, 0, 3'd0, 8'h00, 1, 0, 0, "clr_valid_after");

        // asynchronous reset mid-hold
        step(0, 1, 0, 1, 1, 3'd2, 8'h00, 1, 0, 0, "arst_acc");
        step(0, 1, 0, 1, 0, 3'd0, 8'h04, 0, 1, 0, "arst_h1");
        step(0, 0, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, "arst_low");
        step(0, 1, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, "arst_rel");
        step(0, 1, 0, 1, 0, 3'd0, 8'h00, 1, 0, 0, "arst_idle");

        // active-low, HOLD=1, GAP=0 instance: codes 7 then 0
        step(1, 1, 0, 1, 1, 3'd7, 8'hFF, 1, 0, 0, "al_acc7");
        step(1, 1, 0, 1, 1, 3'd0, 8'h7F, 0, 1, 0, "al_hold7");
        step(1, 1, 0, 1, 1, 3'd0, 8'hFF, 1, 0, 1, "al_acc0");
        step(1, 1, 0, 1, 0, 3'd0, 8'hFE, 0, 1, 0, "al_hold0");
        step(1, 1, 0, 1, 0, 3'd0, 8'hFF, 1, 0, 1, "al_idle");

        bound = 0;
        while (q.size() > 0 && bound < 10) begin
            @(posedge clk);
            bound++;
        end
        @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending rows, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder8_hold.md
Name: decoder8_hold

Overview:
- Sequential 3-to-8 one-hot decoder. It is the consumer-side counterpart of the 8-to-3 priority/one-hot encoder.
- Accepts 3-bit codes over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles.
- After the hold, it enforces a programmable all-off gap before the next code is accepted.
- Typical use: digit/row select and strobe fan-out, where one-hot lines must never overlap.

Parameters:
- HOLD, 4, cycles the one-hot output stays asserted per accepted code; legal range 1..255.
- GAP, 1, all-off cycles inserted after each hold; legal range 0..255 (0 = no gap).
- ACTIVE_LOW, 0, when 1 the onehot output is inverted (asserted line = 0, idle = all ones).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; abort the current hold/gap and return to IDLE.
- en  input  1  enable; when low, acceptance is blocked and HOLD/GAP counting is frozen.
- code_valid  input  1  upstream has a code on code.
- code  input  3  binary code 0..7 to decode.
- code_ready  output  1  block can accept a code this cycle.
- onehot  output  8  decoded one-hot line (polarity set by ACTIVE_LOW).
- busy  output  1  high in HOLD or GAP.
- done  output  1  one-cycle pulse when a hold completes.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE, counter = 0, latched code = 0.
  - onehot = 8'h00 (8'hFF if ACTIVE_LOW).
  - code_ready = 0, busy = 0, done = 0.
- code_ready is 0 during reset and in the first cycle after rst_n deasserts. This first cycle is a registered ready.
- States: IDLE, HOLD, GAP.
- code_ready = (state == IDLE) & en & ~clr. It is a registered-state decode and does not combinationally depend on code_valid.
- Accept occurs when code_valid & code_ready at a rising edge. On accept:
  - code is latched.
  - state goes to HOLD and the counter loads HOLD-1.
  - Latency: onehot shows (1 << code) starting the cycle after the accept edge. It is registered, with no combinational path from code to onehot.
- HOLD:
  - onehot = 1 << latched code (inverted if ACTIVE_LOW).
  - If en = 1: when the counter is 0, leave HOLD; otherwise decrement the counter.
  - If en = 0: the counter and state are frozen and onehot stays asserted.
  - The line is therefore asserted for exactly HOLD enabled cycles.
- Leaving HOLD:
  - If GAP > 0: go to GAP and load the counter with GAP-1.
  - If GAP = 0: go to IDLE.
  - done = 1 for exactly one cycle: the first cycle onehot is de-asserted.
- GAP:
  - onehot is all-off.
  - Counting follows the same en rules as HOLD.
  - At counter 0 with en = 1, go to IDLE.
- busy = 1 exactly when state is HOLD or GAP.
- Back-to-back throughput: one code per HOLD + GAP + 1 cycles. The +1 is the IDLE accept cycle. Outputs never overlap, and at most one onehot bit is ever asserted.
- clr (synchronous):
  - Forces IDLE on the next edge with onehot all-off.
  - done is not pulsed and no accept occurs that cycle.
  - clr together with code_valid: clr wins and the code is not consumed, because ready = 0.
- code_valid while not ready: ignored, with no state effect. Upstream must hold the code until accepted.
- Counter width: 8 bits. Parameter values outside the legal ranges are unsupported.
- Mid-operation reset: immediate return to reset values regardless of state, with no done pulse.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, code_valid = 0 → onehot = 00, code_ready 0 the first cycle then 1, busy = 0, done = 0.
- Single decode (HOLD = 4, GAP = 1, ACTIVE_LOW = 0): accept code = 5 → onehot = 8'h20 for exactly 4 cycles, then 00; done pulse in the first 00 cycle; code_ready returns 2 cycles after the hold ends.
- Back-to-back sweep: code_valid held high, codes 0..7 → onehot 01, 02, 04 … 80 in order, each for 4 cycles, separated by all-off gaps; never two bits set; one accept every 6 cycles.
- Enable freeze: accept code = 3, drop en for 3 cycles mid-hold → 8'h08 held for 4 + 3 = 7 cycles; code_ready stays 0 while en = 0 in IDLE.
- Clear and reset mid-hold: clr on the 2nd hold cycle of code = 6 → onehot 00 next cycle, no done, IDLE. Separately, rst_n pulsed low mid-hold → outputs 00 immediately (asynchronous). clr together with valid → code not accepted.
- Polarity/GAP = 0 variant (ACTIVE_LOW = 1, GAP = 0, HOLD = 1): codes 7 then 0 → FF, 7F (1 cycle), FF (idle/accept cycle), FE (1 cycle), FF.
